// File: rtl/i2s_capture_ctrl.sv
// Capture sequencer between the I2S receiver and the SPI-drained sample FIFO:
// arms on start, optionally waits for an amplitude trigger, writes N slots, then drains.
module i2s_capture_ctrl #(
    parameter int DATA_SIZE = 24,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COUNT_W-1:0]   cfg_sample_count,
    input  logic                 cfg_use_trigger,
    input  logic [DATA_SIZE-2:0] cfg_threshold,
    input  logic                 sample_valid,
    input  logic [DATA_SIZE-1:0] sample_data,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic                 fifo_wr_en,
    output logic [DATA_SIZE-1:0] fifo_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [2:0]           state,
    output logic [COUNT_W-1:0]   sample_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};
    localparam logic [DATA_SIZE-1:0] MAG_MAX  = {1'b0, {(DATA_SIZE-1){1'b1}}};

    state_t                 state_q, state_d;
    logic [COUNT_W-1:0]     n_q, n_d;
    logic                   use_trig_q, use_trig_d;
    logic [DATA_SIZE-2:0]   thr_q, thr_d;
    logic [COUNT_W-1:0]     cnt_q, cnt_d;
    logic                   ov_q, ov_d;
    logic                   wr_en_q, wr_en_d;
    logic [DATA_SIZE-1:0]   wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [DATA_SIZE-1:0]   mag;
    logic                   trigger_hit;
    logic                   take_slot;
    logic                   start_ok;

    // Magnitude saturates so the most-negative code still compares as full scale.
    always_comb begin
        mag = sample_data;
        if (sample_data == MOST_NEG) begin
            mag = MAG_MAX;
        end else if (sample_data[DATA_SIZE-1]) begin
            mag = '0 - sample_data;
        end
        trigger_hit = (mag >= {1'b0, thr_q});
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        use_trig_d = use_trig_q;
        thr_d      = thr_q;
        cnt_d      = cnt_q;
        ov_d       = ov_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        take_slot  = 1'b0;
        start_ok   = 1'b0;

        case (state_q)
            ST_IDLE:    start_ok = start;
            ST_ARMED:   take_slot = sample_valid && trigger_hit;
            ST_CAPTURE: take_slot = sample_valid;
            ST_DRAIN: begin
                // The last write must land before the empty flag can be trusted.
                if (fifo_empty && !wr_en_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:    start_ok = start;
            default:    state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            n_d        = cfg_sample_count;
            use_trig_d = cfg_use_trigger;
            thr_d      = cfg_threshold;
            ov_d       = 1'b0;
            cnt_d      = '0;
            if (cfg_sample_count == '0) begin
                state_d = ST_DONE;
            end else if (cfg_use_trigger) begin
                state_d = ST_ARMED;
            end else begin
                state_d = ST_CAPTURE;
            end
        end

        // A dropped sample still consumes its slot so capture length stays fixed.
        if (take_slot) begin
            cnt_d = (cnt_q == n_q) ? cnt_q : cnt_q + 1'b1;
            if (fifo_full) begin
                ov_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = sample_data;
            end
            state_d = (cnt_d == n_q) ? ST_DRAIN : ST_CAPTURE;
        end

        if (abort) begin
            state_d    = ST_IDLE;
            n_d        = n_q;
            use_trig_d = use_trig_q;
            thr_d      = thr_q;
            cnt_d      = '0;
            ov_d       = ov_q;
            wr_en_d    = 1'b0;
            wr_data_d  = wr_data_q;
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            use_trig_q <= 1'b0;
            thr_q      <= '0;
            cnt_q      <= '0;
            ov_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            use_trig_q <= use_trig_d;
            thr_q      <= thr_d;
            cnt_q      <= cnt_d;
            ov_q       <= ov_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ov_q;
    assign state        = state_q;
    assign sample_cnt   = cnt_q;

endmodule
